// File: rtl/demux1x2_32b_pipe_if.sv
// Handshake bundle for demux1x2_32b_pipe: one upstream port, two downstream ports.
// cnt_a/cnt_b exist only when DEMUX_CNT_EN is defined.
interface demux1x2_32b_pipe_if;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a;
  logic        out_a_valid;
  logic        out_a_ready;
  logic [31:0] out_b;
  logic        out_b_valid;
  logic        out_b_ready;
`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  // Driver side: upstream producer plus both downstream consumers.
  modport master (
    output in_data, in_sel, in_valid, out_a_ready, out_b_ready,
    input  in_ready, out_a, out_a_valid, out_b, out_b_valid
`ifdef DEMUX_CNT_EN
    , input cnt_a, cnt_b
`endif
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_a_ready, out_b_ready,
    output in_ready, out_a, out_a_valid, out_b, out_b_valid
`ifdef DEMUX_CNT_EN
    , output cnt_a, cnt_b
`endif
  );
endinterface

// File: rtl/demux1x2_32b_pipe.sv
// 1-to-2 demultiplexer with a one-entry holding register, 1-cycle latency, full throughput.
// Optional delivered-word counters enabled by macro DEMUX_CNT_EN.
module demux1x2_32b_pipe (
  input logic               clk,
  input logic               reset,
  demux1x2_32b_pipe_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StFullA, StFullB} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        in_xfer, a_xfer, b_xfer;

`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_a_q, cnt_a_d;
  logic [15:0] cnt_b_q, cnt_b_d;
`endif

  // Accepting while full is only safe when the held word leaves on the same edge.
  always_comb begin
    bus.in_ready = 1'b1;
    unique case (state_q)
      StFullA: bus.in_ready = bus.out_a_ready;
      StFullB: bus.in_ready = bus.out_b_ready;
      default: bus.in_ready = 1'b1;
    endcase
  end

  assign in_xfer = bus.in_valid & bus.in_ready;
  assign a_xfer  = (state_q == StFullA) & bus.out_a_ready;
  assign b_xfer  = (state_q == StFullB) & bus.out_b_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (in_xfer) begin
      state_d = bus.in_sel ? StFullB : StFullA;
      data_d  = bus.in_data;
    end else if (a_xfer || b_xfer) begin
      state_d = StEmpty;
    end
  end

`ifdef DEMUX_CNT_EN
  always_comb begin
    cnt_a_d = cnt_a_q + {15'd0, a_xfer};
    cnt_b_d = cnt_b_q + {15'd0, b_xfer};
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= 32'h0;
`ifdef DEMUX_CNT_EN
      cnt_a_q <= 16'h0;
      cnt_b_q <= 16'h0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
`ifdef DEMUX_CNT_EN
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
`endif
    end
  end

  assign bus.out_a_valid = (state_q == StFullA);
  assign bus.out_b_valid = (state_q == StFullB);
  assign bus.out_a       = (state_q == StFullA) ? data_q : 32'h0;
  assign bus.out_b       = (state_q == StFullB) ? data_q : 32'h0;

`ifdef DEMUX_CNT_EN
  assign bus.cnt_a = cnt_a_q;
  assign bus.cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux1x2_32b_pipe.sv
// Directed self-checking bench for demux1x2_32b_pipe; counter wrap test runs when
// DEMUX_CNT_EN is defined.
module tb_demux1x2_32b_pipe;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  demux1x2_32b_pipe_if bus ();

  demux1x2_32b_pipe dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_data = 32'hFFFF_FFFF; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    bus.out_a_ready = 1'b0; bus.out_b_ready = 1'b0;
    step(); step();
    checks++; if (bus.out_a_valid !== 1'b0 || bus.out_b_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valids: got a=%b b=%b expected 0 0", bus.out_a_valid, bus.out_b_valid); end
    checks++; if (bus.out_a !== 32'h0 || bus.out_b !== 32'h0) begin
      errors++; $display("FAIL reset_data: got a=%h b=%h expected 0 0", bus.out_a, bus.out_b); end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    bus.in_data = 32'hDEADBEEF; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    bus.out_a_ready = 1'b1; bus.out_b_ready = 1'b0;
    step();
    bus.in_valid = 1'b0; bus.in_data = 32'h5555_5555;
    checks++; if (bus.out_a !== 32'hDEADBEEF || bus.out_a_valid !== 1'b1) begin
      errors++; $display("FAIL basic_a: got %h/%b expected deadbeef/1", bus.out_a, bus.out_a_valid); end
    checks++; if (bus.out_b !== 32'h0 || bus.out_b_valid !== 1'b0) begin
      errors++; $display("FAIL basic_b: got %h/%b expected 0/0", bus.out_b, bus.out_b_valid); end
    step();
    checks++; if (bus.out_a_valid !== 1'b0 || bus.out_a !== 32'h0) begin
      errors++; $display("FAIL basic_drain: got %h/%b expected 0/0", bus.out_a, bus.out_a_valid); end
  endtask

  task automatic test_backpressure();
    bus.in_data = 32'h12345678; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
    bus.out_b_ready = 1'b0; bus.out_a_ready = 1'b0;
    step();
    bus.in_data = 32'h9999_9999; bus.in_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.out_a_ready = i[0];
      #1;
      checks++; if (bus.in_ready !== 1'b0 || bus.out_b !== 32'h12345678 || bus.out_b_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got rdy=%b b=%h v=%b expected 0 12345678 1",
                           i, bus.in_ready, bus.out_b, bus.out_b_valid); end
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_b_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_follow: got %b expected 1", bus.in_ready); end
    step();
    checks++; if (bus.out_b_valid !== 1'b0 || bus.out_a_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got a=%b b=%b expected 0 0", bus.out_a_valid, bus.out_b_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    logic        sels  [4];
    words = '{32'd1, 32'd2, 32'd3, 32'd4};
    sels  = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.out_a_ready = 1'b1; bus.out_b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = words[i]; bus.in_sel = sels[i]; bus.in_valid = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      step();
      if (sels[i] == 1'b0) begin
        checks++; if (bus.out_a !== words[i] || bus.out_a_valid !== 1'b1 || bus.out_b_valid !== 1'b0) begin
          errors++; $display("FAIL stream_a[%0d]: got %h/%b/%b expected %h/1/0",
                             i, bus.out_a, bus.out_a_valid, bus.out_b_valid, words[i]); end
      end else begin
        checks++; if (bus.out_b !== words[i] || bus.out_b_valid !== 1'b1 || bus.out_a_valid !== 1'b0) begin
          errors++; $display("FAIL stream_b[%0d]: got %h/%b/%b expected %h/1/0",
                             i, bus.out_b, bus.out_b_valid, bus.out_a_valid, words[i]); end
      end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_a_valid !== 1'b0 || bus.out_b_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: got a=%b b=%b expected 0 0", bus.out_a_valid, bus.out_b_valid); end
  endtask

  task automatic test_simultaneous();
    bus.out_a_ready = 1'b0; bus.out_b_ready = 1'b0;
    bus.in_data = 32'hAAAA0000; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_a !== 32'hAAAA0000 || bus.out_a_valid !== 1'b1) begin
      errors++; $display("FAIL simul_full_a: got %h/%b expected aaaa0000/1", bus.out_a, bus.out_a_valid); end
    bus.out_a_ready = 1'b1;
    bus.in_data = 32'h0000BBBB; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL simul_ready: got %b expected 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_b !== 32'h0000BBBB || bus.out_b_valid !== 1'b1 ||
                  bus.out_a_valid !== 1'b0 || bus.out_a !== 32'h0) begin
      errors++; $display("FAIL simul_full_b: got b=%h/%b a=%h/%b expected 0000bbbb/1 0/0",
                         bus.out_b, bus.out_b_valid, bus.out_a, bus.out_a_valid); end
    bus.out_b_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    bus.out_a_ready = 1'b0; bus.out_b_ready = 1'b0;
    bus.in_data = 32'hCAFE_F00D; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
    step();
    checks++; if (bus.out_b_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_loaded: got %b expected 1", bus.out_b_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.out_b_valid !== 1'b0 || bus.out_b !== 32'h0) begin
      errors++; $display("FAIL rmid_immediate: got %h/%b expected 0/0", bus.out_b, bus.out_b_valid); end
    bus.in_sel = 1'b0;
    step();
    checks++; if (bus.out_a_valid !== 1'b0 || bus.out_b_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_no_capture: got a=%b b=%b expected 0 0", bus.out_a_valid, bus.out_b_valid); end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    bus.out_b_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); end
    step();
    checks++; if (bus.out_b_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_discard: got %b expected 0", bus.out_b_valid); end
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counters();
    reset = 1'b1; bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
    checks++; if (bus.cnt_a !== 16'h0 || bus.cnt_b !== 16'h0) begin
      errors++; $display("FAIL cnt_reset: got %h %h expected 0 0", bus.cnt_a, bus.cnt_b); end
    bus.out_a_ready = 1'b1; bus.out_b_ready = 1'b1;
    bus.in_sel = 1'b0; bus.in_data = 32'h1; bus.in_valid = 1'b1;
    // 65535 loads with pipelined delivery: last word drains on the extra step.
    for (int i = 0; i < 65535; i++) step();
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.cnt_a !== 16'hFFFF || bus.cnt_b !== 16'h0) begin
      errors++; $display("FAIL cnt_preload: got %h %h expected ffff 0", bus.cnt_a, bus.cnt_b); end
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.cnt_a !== 16'h0 || bus.cnt_b !== 16'h0) begin
      errors++; $display("FAIL cnt_wrap: got %h %h expected 0 0", bus.cnt_a, bus.cnt_b); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
`ifdef DEMUX_CNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
